// File: rtl/mtpsa_pkg.sv
// Shared field offsets, widths and types for the MTPSA digest extractor.
// The build option MTPSA_DIGEST_DROP_CNT_EN is consumed by the top module, not here.
package mtpsa_pkg;

  localparam int C_AXIS_DATA_WIDTH    = 256;
  localparam int C_S_AXIS_TUSER_WIDTH = 304;
  localparam int C_M_AXIS_TUSER_WIDTH = 128;
  localparam int DIGEST_WIDTH         = 256;
  localparam int DIG_TUSER_WIDTH      = 16;

  // Input tuser layout, chained so each field follows the previous one.
  localparam int LEN        = 0;
  localparam int SRC        = LEN + 16;
  localparam int DST        = SRC + 8;
  localparam int UID        = DST + 8;
  localparam int SEND_DIG   = UID + 8;
  localparam int DIG_LSB    = SEND_DIG + 8;
  localparam int META_WIDTH = DIG_LSB;

  typedef struct packed {
    logic [7:0]              uid;
    logic [7:0]              src;
    logic [DIGEST_WIDTH-1:0] digest;
  } dig_rec_t;

  localparam int DIG_REC_WIDTH = $bits(dig_rec_t);

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_AXIS_DATA_WIDTH/8-1:0] tkeep;
    logic [META_WIDTH-1:0]          meta;
    logic                           tlast;
  } beat_t;

  typedef enum logic {
    SOP_IDLE = 1'b0,
    SOP_BODY = 1'b1
  } sop_state_e;

endpackage

// File: rtl/mtpsa_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit.
// A push while full is accepted when a pop happens in the same cycle.
module mtpsa_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en    = pop & ~empty;
  assign wr_en    = push & (~full | rd_en);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mtpsa_digest_extractor.sv
// Splits the 304-bit-tuser SDNet stream into a SUME packet stream and a digest record stream.
// Define MTPSA_DIGEST_DROP_CNT_EN to add the saturating digest_drop_cnt output.
module mtpsa_digest_extractor
  import mtpsa_pkg::*;
#(
  parameter int DIG_FIFO_DEPTH = 4
) (
  input  logic                              clk_line,
  input  logic                              clk_line_rst,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [DIGEST_WIDTH-1:0]           m_dig_tdata,
  output logic [DIG_TUSER_WIDTH-1:0]        m_dig_tuser,
  output logic                              m_dig_tvalid,
  input  logic                              m_dig_tready
`ifdef MTPSA_DIGEST_DROP_CNT_EN
  ,
  output logic [31:0]                       digest_drop_cnt
`endif
);

  beat_t      in_beat;
  beat_t      out_beat_q, out_beat_d;
  beat_t      skid_beat_q, skid_beat_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       ready_q, ready_d;
  logic       accept, out_ready;
  sop_state_e state_q, state_d;

  assign in_beat = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep,
                     meta: s_axis_tuser[LEN +: META_WIDTH], tlast: s_axis_tlast};
  assign accept    = s_axis_tvalid & ready_q;
  assign out_ready = m_axis_tready | ~out_valid_q;

  // Skid pair: the second slot only fills while the output is stalled, so ready can be registered.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_beat_d   = out_beat_q;
    skid_valid_d = skid_valid_q;
    skid_beat_d  = skid_beat_q;
    if (skid_valid_q) begin
      if (out_ready) begin
        out_valid_d  = 1'b1;
        out_beat_d   = skid_beat_q;
        skid_valid_d = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = accept;
      if (accept) out_beat_d = in_beat;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_beat_d  = in_beat;
    end
    ready_d = ~skid_valid_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        SOP_IDLE: state_d = s_axis_tlast ? SOP_IDLE : SOP_BODY;
        SOP_BODY: state_d = s_axis_tlast ? SOP_IDLE : SOP_BODY;
        default:  state_d = SOP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      state_q      <= SOP_IDLE;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
      state_q      <= state_d;
    end
  end

  always_ff @(posedge clk_line) begin
    out_beat_q  <= out_beat_d;
    skid_beat_q <= skid_beat_d;
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_beat_q.tdata;
  assign m_axis_tkeep  = out_beat_q.tkeep;
  assign m_axis_tlast  = out_beat_q.tlast;
  assign m_axis_tuser  = {{(C_M_AXIS_TUSER_WIDTH-META_WIDTH){1'b0}}, out_beat_q.meta};

  logic     dig_capture, dig_pop, dig_full, dig_empty;
  dig_rec_t dig_in, dig_out;

  assign dig_capture = accept & (state_q == SOP_IDLE) & s_axis_tuser[SEND_DIG];
  assign dig_pop     = m_dig_tready & ~dig_empty;
  assign dig_in      = '{uid: s_axis_tuser[UID +: 8], src: s_axis_tuser[SRC +: 8],
                         digest: s_axis_tuser[DIG_LSB +: DIGEST_WIDTH]};

  mtpsa_sync_fifo #(
    .WIDTH (DIG_REC_WIDTH),
    .DEPTH (DIG_FIFO_DEPTH)
  ) u_dig_fifo (
    .clk       (clk_line),
    .srst      (clk_line_rst),
    .push      (dig_capture),
    .push_data (dig_in),
    .full      (dig_full),
    .pop       (dig_pop),
    .pop_data  (dig_out),
    .empty     (dig_empty)
  );

  assign m_dig_tvalid = ~dig_empty;
  assign m_dig_tdata  = dig_out.digest;
  assign m_dig_tuser  = {dig_out.uid, dig_out.src};

`ifdef MTPSA_DIGEST_DROP_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // A capture is lost only when the FIFO is full and nothing leaves it this cycle.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (dig_capture && dig_full && !dig_pop && (drop_cnt_q != 32'hFFFF_FFFF))
      drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) drop_cnt_q <= '0;
    else              drop_cnt_q <= drop_cnt_d;
  end

  assign digest_drop_cnt = drop_cnt_q;
`endif

endmodule
